rast_bbox: RTL and testbench

- First RTL stage of the rasteriser. Accepts one triangle per cycle from the input driver (R10) and culls backfacing, degenerate and fully off-screen triangles.
- Computes a screen-clipped bounding box snapped to the MSAA subsample grid.
- Presents triangle, colour and box to the sample-test iterator at R13.
- Three-stage pipeline (R11, R12, R13) with global halt-based backpressure.

---
 rtl/rast_bbox_pkg.sv | 39 +++
 rtl/rast_bbox_snap.sv | 33 +++
 rtl/rast_bbox.sv | 154 +++++++++++++++
 tb/tb_rast_bbox.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rast_bbox_pkg.sv
// Shared fixed-point types, MSAA encodings and helpers for the bounding-box stage.
package rast_pkg;

   localparam int SIGFIG  = 24;            // bits in colour and position values
   localparam int RADIX   = 10;            // fraction bits
   localparam int VERTS   = 3;             // vertices per triangle
   localparam int AXIS    = 3;             // x, y, z per vertex
   localparam int COLORS  = 3;             // colour channels
   localparam int CROSS_W = 2*SIGFIG + 3;  // full-precision edge cross product

   typedef logic signed [SIGFIG-1:0]  coord_t;
   typedef logic        [SIGFIG-1:0]  color_t;
   typedef logic signed [SIGFIG:0]    edge_t;
   typedef logic signed [CROSS_W-1:0] cross_t;
   typedef coord_t vert_t [AXIS];

   typedef struct packed {
      coord_t min_x;
      coord_t min_y;
      coord_t max_x;
      coord_t max_y;
   } box_t;

   localparam logic [3:0] SS_X1  = 4'b1000;
   localparam logic [3:0] SS_X4  = 4'b0100;
   localparam logic [3:0] SS_X16 = 4'b0010;
   localparam logic [3:0] SS_X64 = 4'b0001;

   // log2 of the per-axis subsample count; anything not one-hot behaves as x1
   function automatic logic [1:0] ss_lg2(input logic [3:0] ss);
      case (ss)
         SS_X4:   return 2'd1;
         SS_X16:  return 2'd2;
         SS_X64:  return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/rast_bbox_snap.sv
// One axis of the box: snap min/max down to the subsample grid, then clip to the screen.
module rast_bbox_snap
   import rast_pkg::*;
(
   input  logic signed [SIGFIG-1:0] min_raw,
   input  logic signed [SIGFIG-1:0] max_raw,
   input  logic signed [SIGFIG-1:0] screen,
   input  logic [1:0]               lg2,
   output logic signed [SIGFIG-1:0] min_clip,
   output logic signed [SIGFIG-1:0] max_clip,
   output logic                     offscreen
);

   coord_t step;
   coord_t mask;
   coord_t min_snap;
   coord_t max_snap;
   coord_t max_lim;

   // Clearing low bits of a two's-complement value rounds toward -inf.
   // The off-screen test uses the snapped (unclipped) extents.
   always_comb begin
      step      = coord_t'(1) << (RADIX - int'(lg2));
      mask      = ~(step - coord_t'(1));
      min_snap  = min_raw & mask;
      max_snap  = max_raw & mask;
      max_lim   = screen - step;
      offscreen = max_snap[SIGFIG-1] | (min_snap >= screen);
      min_clip  = min_snap[SIGFIG-1] ? '0 : min_snap;
      max_clip  = (max_snap > max_lim) ? max_lim : max_snap;
   end

endmodule

// File: rtl/rast_bbox.sv
// Rasteriser front stage: cull back-facing/degenerate/off-screen triangles and
// produce a grid-snapped, screen-clipped bounding box. Stages R11, R12, R13
// all advance together whenever the downstream stage is ready.
module rast_bbox
   import rast_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [SIGFIG-1:0] tri_R10S [VERTS][AXIS],
   input  logic        [SIGFIG-1:0] color_R10U [COLORS],
   input  logic                     validTri_R10H,
   input  logic signed [SIGFIG-1:0] screen_RnnnnS [2],
   input  logic [3:0]               subSample_RnnnnU,
   input  logic                     halt_R13L,
   output logic                     halt_RnnnnL,
   output logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
   output logic        [SIGFIG-1:0] color_R13U [COLORS],
   output logic signed [SIGFIG-1:0] box_R13S [2][2],
   output logic                     validTri_R13H
);

   logic adv;

   edge_t  e0_x, e0_y, e1_x, e1_y;
   cross_t cross_R10;
   box_t   raw_R10;

   logic   vld_R11, cull_R11;
   vert_t  tri_R11 [VERTS];
   color_t color_R11 [COLORS];
   box_t   box_R11;

   logic [1:0] lg2_R11;
   box_t   clip_R11;
   logic   off_x_R11, off_y_R11;

   logic   vld_R12, cull_R12, off_R12;
   vert_t  tri_R12 [VERTS];
   color_t color_R12 [COLORS];
   box_t   box_R12;

   assign halt_RnnnnL = halt_R13L;
   assign adv         = halt_R13L;

   // Edge vectors, winding cross product and raw x/y extents of the incoming triangle
   always_comb begin
      e0_x = edge_t'(tri_R10S[1][0]) - edge_t'(tri_R10S[0][0]);
      e0_y = edge_t'(tri_R10S[1][1]) - edge_t'(tri_R10S[0][1]);
      e1_x = edge_t'(tri_R10S[2][0]) - edge_t'(tri_R10S[1][0]);
      e1_y = edge_t'(tri_R10S[2][1]) - edge_t'(tri_R10S[1][1]);
      cross_R10 = cross_t'(e0_x) * cross_t'(e1_y) - cross_t'(e0_y) * cross_t'(e1_x);
      raw_R10.min_x = tri_R10S[0][0];
      raw_R10.max_x = tri_R10S[0][0];
      raw_R10.min_y = tri_R10S[0][1];
      raw_R10.max_y = tri_R10S[0][1];
      for (int v = 1; v < VERTS; v++) begin
         if (tri_R10S[v][0] < raw_R10.min_x) raw_R10.min_x = tri_R10S[v][0];
         if (tri_R10S[v][0] > raw_R10.max_x) raw_R10.max_x = tri_R10S[v][0];
         if (tri_R10S[v][1] < raw_R10.min_y) raw_R10.min_y = tri_R10S[v][1];
         if (tri_R10S[v][1] > raw_R10.max_y) raw_R10.max_y = tri_R10S[v][1];
      end
   end

   // ---- R10 -> R11: edges and extents ----
   // Register triangle, colour, cull flag and raw box
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_R11  <= 1'b0;
         cull_R11 <= 1'b0;
         box_R11  <= '0;
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) tri_R11[v][a] <= '0;
         for (int c = 0; c < COLORS; c++) color_R11[c] <= '0;
      end else if (adv) begin
         vld_R11  <= validTri_R10H;
         cull_R11 <= ~cross_R10[CROSS_W-1];
         box_R11  <= raw_R10;
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) tri_R11[v][a] <= tri_R10S[v][a];
         for (int c = 0; c < COLORS; c++) color_R11[c] <= color_R10U[c];
      end
   end

   assign lg2_R11 = ss_lg2(subSample_RnnnnU);

   rast_bbox_snap u_snap_x (
      .min_raw   (box_R11.min_x),
      .max_raw   (box_R11.max_x),
      .screen    (screen_RnnnnS[0]),
      .lg2       (lg2_R11),
      .min_clip  (clip_R11.min_x),
      .max_clip  (clip_R11.max_x),
      .offscreen (off_x_R11)
   );

   rast_bbox_snap u_snap_y (
      .min_raw   (box_R11.min_y),
      .max_raw   (box_R11.max_y),
      .screen    (screen_RnnnnS[1]),
      .lg2       (lg2_R11),
      .min_clip  (clip_R11.min_y),
      .max_clip  (clip_R11.max_y),
      .offscreen (off_y_R11)
   );

   // ---- R11 -> R12: snap and clip ----
   // Register snapped/clipped box and the off-screen verdict
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_R12  <= 1'b0;
         cull_R12 <= 1'b0;
         off_R12  <= 1'b0;
         box_R12  <= '0;
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) tri_R12[v][a] <= '0;
         for (int c = 0; c < COLORS; c++) color_R12[c] <= '0;
      end else if (adv) begin
         vld_R12  <= vld_R11;
         cull_R12 <= cull_R11;
         off_R12  <= off_x_R11 | off_y_R11;
         box_R12  <= clip_R11;
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) tri_R12[v][a] <= tri_R11[v][a];
         for (int c = 0; c < COLORS; c++) color_R12[c] <= color_R11[c];
      end
   end

   // ---- R12 -> R13: output ----
   // Data loads on every advance; only the valid bit carries the cull decision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         validTri_R13H <= 1'b0;
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) box_R13S[i][j] <= '0;
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) tri_R13S[v][a] <= '0;
         for (int c = 0; c < COLORS; c++) color_R13U[c] <= '0;
      end else if (adv) begin
         validTri_R13H  <= vld_R12 & ~cull_R12 & ~off_R12;
         box_R13S[0][0] <= box_R12.min_x;
         box_R13S[0][1] <= box_R12.min_y;
         box_R13S[1][0] <= box_R12.max_x;
         box_R13S[1][1] <= box_R12.max_y;
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) tri_R13S[v][a] <= tri_R12[v][a];
         for (int c = 0; c < COLORS; c++) color_R13U[c] <= color_R12[c];
      end
   end

   // MSAA mode must be one-hot; other encodings silently fall back to x1
   a_ss_onehot : assert property (@(posedge clk) disable iff (rst) $onehot(subSample_RnnnnU))
      else $error("rast_bbox: subSample_RnnnnU not one-hot: %b", subSample_RnnnnU);

endmodule

// File: tb/tb_rast_bbox.sv
// Testbench for rast_bbox: directed vector table, randomized streams against a
// floor-division reference model, backpressure and reset sequences.
module tb_rast_bbox;
   import rast_pkg::*;

   localparam int SCR = 'h80000;

   logic clk = 1'b0;
   logic rst;
   logic signed [SIGFIG-1:0] tri_R10S [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R10U [COLORS];
   logic                     validTri_R10H;
   logic signed [SIGFIG-1:0] screen_RnnnnS [2];
   logic [3:0]               subSample_RnnnnU;
   logic                     halt_R13L;
   logic                     halt_RnnnnL;
   logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R13U [COLORS];
   logic signed [SIGFIG-1:0] box_R13S [2][2];
   logic                     validTri_R13H;

   int checks = 0;
   int failures = 0;

   rast_bbox dut (
      .clk              (clk),
      .rst              (rst),
      .tri_R10S         (tri_R10S),
      .color_R10U       (color_R10U),
      .validTri_R10H    (validTri_R10H),
      .screen_RnnnnS    (screen_RnnnnS),
      .subSample_RnnnnU (subSample_RnnnnU),
      .halt_R13L        (halt_R13L),
      .halt_RnnnnL      (halt_RnnnnL),
      .tri_R13S         (tri_R13S),
      .color_R13U       (color_R13U),
      .box_R13S         (box_R13S),
      .validTri_R13H    (validTri_R13H)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0][2:0][23:0] p;   // [vertex][axis]
      logic [2:0][23:0]      c;
   } tri_t;

   typedef struct packed {
      logic              v;
      logic signed [23:0] mnx, mny, mxx, mxy;
   } exp_t;

   typedef struct {
      int x0, y0, x1, y1, x2, y2;
      logic [3:0] ss;
      bit v;
      int mnx, mny, mxx, mxy;
   } vec_t;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Reference: plain integer geometry with floor-to-grid rounding
   function automatic longint floor_to(input longint v, input longint s);
      if (v >= 0) return (v / s) * s;
      return -(((-v) + s - 1) / s) * s;
   endfunction

   function automatic exp_t model(input tri_t t, input logic [3:0] ss);
      longint x[3], y[3];
      longint mnx, mny, mxx, mxy, step, cr;
      int lg2;
      bit off;
      exp_t e;
      for (int v = 0; v < 3; v++) begin
         x[v] = longint'($signed(t.p[v][0]));
         y[v] = longint'($signed(t.p[v][1]));
      end
      case (ss)
         4'b0100: lg2 = 1;
         4'b0010: lg2 = 2;
         4'b0001: lg2 = 3;
         default: lg2 = 0;
      endcase
      step = longint'(1) << (10 - lg2);
      cr = (x[1] - x[0]) * (y[2] - y[1]) - (y[1] - y[0]) * (x[2] - x[1]);
      mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
      for (int v = 1; v < 3; v++) begin
         if (x[v] < mnx) mnx = x[v];
         if (x[v] > mxx) mxx = x[v];
         if (y[v] < mny) mny = y[v];
         if (y[v] > mxy) mxy = y[v];
      end
      mnx = floor_to(mnx, step); mxx = floor_to(mxx, step);
      mny = floor_to(mny, step); mxy = floor_to(mxy, step);
      off = (mxx < 0) || (mxy < 0) || (mnx >= SCR) || (mny >= SCR);
      if (mnx < 0) mnx = 0;
      if (mny < 0) mny = 0;
      if (mxx > SCR - step) mxx = SCR - step;
      if (mxy > SCR - step) mxy = SCR - step;
      e.v   = (cr < 0) && !off;
      e.mnx = mnx[23:0]; e.mny = mny[23:0];
      e.mxx = mxx[23:0]; e.mxy = mxy[23:0];
      return e;
   endfunction

   function automatic tri_t mk(input int x0, input int y0, input int x1, input int y1,
                               input int x2, input int y2);
      tri_t t;
      t.p[0][0] = x0[23:0]; t.p[0][1] = y0[23:0];
      t.p[1][0] = x1[23:0]; t.p[1][1] = y1[23:0];
      t.p[2][0] = x2[23:0]; t.p[2][1] = y2[23:0];
      for (int v = 0; v < 3; v++) t.p[v][2] = 24'($urandom);
      for (int c = 0; c < 3; c++) t.c[c] = 24'($urandom);
      return t;
   endfunction

   // Front-facing, on-screen by construction unless arbitrary is set
   function automatic tri_t gen(input bit arbitrary);
      int a, b, dx1, dx2, dy;
      if (arbitrary)
         return mk(int'($urandom_range(0, 'hA0000)) - 'h10000, int'($urandom_range(0, 'hA0000)) - 'h10000,
                   int'($urandom_range(0, 'hA0000)) - 'h10000, int'($urandom_range(0, 'hA0000)) - 'h10000,
                   int'($urandom_range(0, 'hA0000)) - 'h10000, int'($urandom_range(0, 'hA0000)) - 'h10000);
      a   = int'($urandom_range(0, 'h70000));
      b   = int'($urandom_range(0, 'h70000));
      dx1 = int'($urandom_range(0, 'h8000)) - 'h4000;
      dx2 = int'($urandom_range(1, 'h8000));
      dy  = int'($urandom_range(1, 'h8000));
      return mk(a, b, a + dx1, b + dy, a + dx2, b);
   endfunction

   task automatic drive(input tri_t t);
      for (int v = 0; v < 3; v++)
         for (int a = 0; a < 3; a++) tri_R10S[v][a] = t.p[v][a];
      for (int c = 0; c < 3; c++) color_R10U[c] = t.c[c];
   endtask

   task automatic chk_out(input string tag, input exp_t e, input tri_t t);
      chk({tag, "_min_x"}, box_R13S[0][0], e.mnx);
      chk({tag, "_min_y"}, box_R13S[0][1], e.mny);
      chk({tag, "_max_x"}, box_R13S[1][0], e.mxx);
      chk({tag, "_max_y"}, box_R13S[1][1], e.mxy);
      for (int v = 0; v < 3; v++)
         for (int a = 0; a < 3; a++) chk({tag, "_tri"}, $signed(tri_R13S[v][a]), $signed(t.p[v][a]));
      for (int c = 0; c < 3; c++) chk({tag, "_color"}, {1'b0, color_R13U[c]}, {1'b0, t.c[c]});
   endtask

   task automatic run_stream(input int n, input bit arbitrary, input bit rnd_halt, input logic [3:0] ss);
      exp_t eq[$];
      tri_t tq[$];
      exp_t e;
      tri_t t, to;
      int sent = 0;
      int cyc = 0;
      bit h;
      subSample_RnnnnU = ss;
      t = gen(arbitrary);
      while ((sent < n || eq.size() > 0) && cyc < 3000) begin
         @(negedge clk);
         h = rnd_halt ? bit'($urandom_range(0, 1)) : 1'b1;
         halt_R13L = h;
         validTri_R10H = (sent < n);
         drive(t);
         #1;
         chk("halt_mirror", halt_RnnnnL, h);
         if (validTri_R13H && h) begin
            if (eq.size() == 0) fail("stream_extra_output");
            else begin
               e  = eq.pop_front();
               to = tq.pop_front();
               chk_out("stream", e, to);
            end
         end
         @(posedge clk);
         if (h && sent < n) begin
            e = model(t, ss);
            if (e.v) begin
               eq.push_back(e);
               tq.push_back(t);
            end
            sent++;
            t = gen(arbitrary);
         end
         cyc++;
      end
      @(negedge clk);
      validTri_R10H = 1'b0;
      halt_R13L = 1'b1;
      chk("stream_drained", eq.size(), 0);
   endtask

   vec_t vt[15];
   tri_t t;
   exp_t e;

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0]  = '{'h500, 'h800, 'h1400, 'h2600, 'h2B00, 'h800, SS_X4, 1, 'h400, 'h800, 'h2A00, 'h2600};
      vt[1]  = '{'h500, 'h800, 'h2B00, 'h800, 'h1400, 'h2600, SS_X4, 0, 0, 0, 0, 0};
      vt[2]  = '{'h500, 'h800, 'h1400, 'h800, 'h2800, 'h800, SS_X4, 0, 0, 0, 0, 0};
      vt[3]  = '{'h81000, 'h800, 'h85000, 'h2600, 'h90000, 'h800, SS_X4, 0, 0, 0, 0, 0};
      vt[4]  = '{-'hC00, 'h800, 'h1400, 'h2600, 'h2B00, 'h800, SS_X4, 1, 0, 'h800, 'h2A00, 'h2600};
      vt[5]  = '{'h7F000, 'h800, 'h80400, 'h2600, 'h81000, 'h800, SS_X4, 1, 'h7F000, 'h800, 'h7FE00, 'h2600};
      vt[6]  = '{'h80000, 'h800, 'h80400, 'h2600, 'h81000, 'h800, SS_X4, 0, 0, 0, 0, 0};
      vt[7]  = '{'h500, -'h3000, 'h1400, -'h1200, 'h2B00, -'h3000, SS_X4, 0, 0, 0, 0, 0};
      vt[8]  = '{'h577, 'h800, 'h1400, 'h2600, 'h2B00, 'h800, SS_X1, 1, 'h400, 'h800, 'h2800, 'h2400};
      vt[9]  = '{'h577, 'h800, 'h1400, 'h2600, 'h2B00, 'h800, SS_X4, 1, 'h400, 'h800, 'h2A00, 'h2600};
      vt[10] = '{'h577, 'h800, 'h1400, 'h2600, 'h2B00, 'h800, SS_X16, 1, 'h500, 'h800, 'h2B00, 'h2600};
      vt[11] = '{'h577, 'h800, 'h1400, 'h2600, 'h2B00, 'h800, SS_X64, 1, 'h500, 'h800, 'h2B00, 'h2600};
      vt[12] = '{'h5F7, 'h800, 'h1400, 'h2600, 'h2B00, 'h800, SS_X64, 1, 'h580, 'h800, 'h2B00, 'h2600};
      vt[13] = '{'h400, 'h800, 'h1400, 'h2800, 'h2C00, 'h800, SS_X1, 1, 'h400, 'h800, 'h2C00, 'h2800};
      vt[14] = '{'h500, 'h80000, 'h1400, 'h81E00, 'h2B00, 'h80000, SS_X4, 0, 0, 0, 0, 0};

      // Reset state and combinational halt mirror
      rst = 1'b1;
      halt_R13L = 1'b0;
      validTri_R10H = 1'b0;
      subSample_RnnnnU = SS_X4;
      screen_RnnnnS[0] = 24'(SCR);
      screen_RnnnnS[1] = 24'(SCR);
      drive(mk(0, 0, 0, 0, 0, 0));
      #1;
      chk("reset_valid", validTri_R13H, 0);
      chk("reset_box_min_x", box_R13S[0][0], 0);
      chk("reset_box_max_y", box_R13S[1][1], 0);
      chk("reset_tri", tri_R13S[1][1], 0);
      chk("reset_color", {1'b0, color_R13U[2]}, 0);
      chk("reset_halt_lo", halt_RnnnnL, 0);
      halt_R13L = 1'b1;
      #1;
      chk("reset_halt_hi", halt_RnnnnL, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed vector table
      for (int i = 0; i < 15; i++) begin
         t = mk(vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].x2, vt[i].y2);
         @(negedge clk);
         subSample_RnnnnU = vt[i].ss;
         halt_R13L = 1'b1;
         drive(t);
         validTri_R10H = 1'b1;
         @(negedge clk);
         validTri_R10H = 1'b0;
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), validTri_R13H, vt[i].v);
         if (vt[i].v) begin
            e.v = 1'b1;
            e.mnx = vt[i].mnx[23:0]; e.mny = vt[i].mny[23:0];
            e.mxx = vt[i].mxx[23:0]; e.mxy = vt[i].mxy[23:0];
            chk_out($sformatf("vec%0d", i), e, t);
         end
      end

      // Randomized streams with and without backpressure
      run_stream(20, 1'b0, 1'b1, SS_X4);
      run_stream(40, 1'b1, 1'b1, SS_X16);
      run_stream(30, 1'b1, 1'b0, SS_X64);
      run_stream(20, 1'b1, 1'b1, SS_X1);

      // Mid-stream reset with the pipeline full
      subSample_RnnnnU = SS_X4;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         halt_R13L = 1'b1;
         drive(gen(1'b0));
         validTri_R10H = 1'b1;
      end
      @(negedge clk);
      validTri_R10H = 1'b0;
      chk("prefill_valid", validTri_R13H, 1);
      rst = 1'b1;
      #1;
      chk("midrst_valid", validTri_R13H, 0);
      chk("midrst_box_min_x", box_R13S[0][0], 0);
      chk("midrst_box_max_x", box_R13S[1][0], 0);
      chk("midrst_tri", tri_R13S[0][0], 0);
      chk("midrst_color", {1'b0, color_R13U[0]}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("flushed_no_output", validTri_R13H, 0);
      end

      // First triangle after reset with stalls interleaved: 3 advancing edges
      t = gen(1'b0);
      e = model(t, SS_X4);
      drive(t);
      validTri_R10H = 1'b1;
      halt_R13L = 1'b1;
      @(negedge clk);                        // advance 1
      drive(gen(1'b0));                      // presented while stalled: must be ignored
      halt_R13L = 1'b0;
      chk("lat_adv1", validTri_R13H, 0);
      @(negedge clk);                        // hold
      validTri_R10H = 1'b0;
      halt_R13L = 1'b1;
      chk("lat_hold", validTri_R13H, 0);
      @(negedge clk);                        // advance 2
      chk("lat_adv2", validTri_R13H, 0);
      @(negedge clk);                        // advance 3
      chk("lat_adv3_valid", validTri_R13H, 1);
      chk_out("lat", e, t);
      @(negedge clk);
      chk("lat_no_duplicate", validTri_R13H, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
